// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and the
// quotient fill value reported on divide-by-zero.
package sequential_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Divide-by-zero reports a quotient with every bit set to this value.
  localparam logic DIV_ZERO_Q_BIT = 1'b1;

  // Step counter width: one spare bit so a count of WIDTH never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sequential_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and restore on borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             diff_top_unused;
  logic             borrow;

  assign shifted = {rem, dvd_msb};

  // WIDTH+1 bit trial subtract; the borrow out decides restore vs. keep.
  // On no-borrow the difference is below divisor, so its top bit is always 0.
  assign {borrow, diff_top_unused, diff} = {1'b0, shifted} - {2'b00, divisor};

  assign q_bit    = ~borrow;
  assign rem_next = borrow ? shifted[WIDTH-1:0] : diff;

endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring divider, one quotient bit per clock. start/busy/done
// handshake; divide-by-zero returns all-ones quotient and the dividend as
// remainder with div_by_zero set.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;   // dividend shifts out the top, quotient shifts in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  // FSM, datapath registers and registered outputs.
  // A zero divisor passes through CALC once with busy low, so its done
  // lands one edge after accept; a nonzero divisor runs WIDTH steps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            dvd   <= dividend;
            dvs   <= divisor;
            rem   <= '0;
            cnt   <= '0;
            state <= S_CALC;
            busy  <= (divisor != '0);
          end
        end
        S_CALC: begin
          if (dvs == '0) begin
            state       <= S_DONE;
            done        <= 1'b1;
            quotient    <= {WIDTH{DIV_ZERO_Q_BIT}};
            remainder   <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            rem <= rem_nx;
            dvd <= {dvd[WIDTH-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state       <= S_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= {dvd[WIDTH-2:0], q_bit};
              remainder   <= rem_nx;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Bench for sequential_divider (WIDTH=8): arithmetic reference model with a
// per-cycle compare, directed vectors with literal results, random sweep.
module tb_sequential_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op completes a fixed number of edges later
  // with results from plain / and %.
  int           m_cnt;
  logic         m_busy, m_done, m_dbz, m_pdbz;
  logic [W-1:0] m_q, m_r, m_pq, m_pr, m_a, m_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0; m_busy <= 0; m_done <= 0; m_dbz <= 0; m_pdbz <= 0;
      m_q <= 0; m_r <= 0; m_pq <= 0; m_pr <= 0; m_a <= 0; m_b <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= m_pq;
          m_r    <= m_pr;
          m_dbz  <= m_pdbz;
        end
      end else if (start) begin
        m_a    <= dividend;
        m_b    <= divisor;
        m_cnt  <= (divisor == 0) ? 1 : W;
        m_busy <= (divisor != 0);
        m_pdbz <= (divisor == 0);
        m_pq   <= (divisor == 0) ? {W{1'b1}} : dividend / divisor;
        m_pr   <= (divisor == 0) ? dividend : dividend % divisor;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("div_by_zero", div_by_zero, m_dbz);
      if (done && !div_by_zero) begin
        check("identity", 32'(quotient) * 32'(m_b) + 32'(remainder), 32'(m_a));
        check("rem_lt_div", 32'(remainder < m_b), 32'd1);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #2;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc = edges since the call, bc = cycles busy seen.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 0; bc = 0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      @(posedge clk); #2;
      cyc++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int eq, input int er, input int edbz,
                       input int elat, input int ebusy);
    int cyc, bc;
    issue(a, b);
    wait_done(cyc, bc);
    check("lat", cyc, elat);
    check("busy_cycles", bc, ebusy);
    check("q", quotient, eq);
    check("r", remainder, er);
    check("dbz", div_by_zero, edbz);
    check("model_q", m_q, eq);
    check("model_r", m_r, er);
  endtask

  initial begin
    int cyc, bc;
    logic [W-1:0] a, b;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(posedge clk); #2 reset_n = 1'b1;

    do_op(8'd100, 8'd7,  14, 2,   0, 8, 8);
    do_op(8'd255, 8'd1,  255, 0,  0, 8, 8);
    do_op(8'd5,   8'd9,  0,   5,  0, 8, 8);
    do_op(8'd0,   8'd3,  0,   0,  0, 8, 8);
    do_op(8'd200, 8'd0,  255, 200, 1, 1, 0);
    do_op(8'd255, 8'd200, 1,  55, 0, 8, 8);
    do_op(8'd200, 8'd250, 0, 200, 0, 8, 8);

    // Start while busy is ignored.
    issue(8'd100, 8'd7);
    repeat (2) begin @(posedge clk); #2; end
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(cyc, bc);
    check("ign_q", quotient, 14);
    check("ign_r", remainder, 2);

    // Back-to-back start in the done cycle.
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(posedge clk); #2;
    start = 1'b0;
    check("b2b_done_drop", done, 0);
    check("b2b_busy", busy, 1);
    wait_done(cyc, bc);
    check("b2b_lat", cyc, 8);
    check("b2b_q", quotient, 4);
    check("b2b_r", remainder, 1);

    // Reset mid-operation clears everything immediately.
    issue(8'd100, 8'd7);
    repeat (3) begin @(posedge clk); #2; end
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    do_op(8'd9, 8'd2, 4, 1, 0, 8, 8);

    // Random sweep; the per-cycle compare carries the checking.
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      issue(a, b);
      wait_done(cyc, bc);
    end

    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
